muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs the arithmetic, and holds the pipeline with `stall_o` while it works. It drives the HI/LO register file's two-bit write enable and write data.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/div_radix2.sv | 44 ++++
 rtl/muldiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Op codes, FSM state encoding, iteration default and HI/LO write-enable bits.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int DIV_ITERS_DEF = 32;

  localparam int HILO_WE_HI = 1;
  localparam int HILO_WE_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_DONE = 3'd3,
    S_MTW  = 3'd4
  } state_t;

  // Multi-cycle ops that hold the pipeline
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Restoring radix-2 divider datapath: one quotient bit per step.
// Operates on magnitudes; sign handling lives in the controller.
module div_radix2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] q_r, r_r, d_r;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // When ge holds, the difference is below the divisor and fits in 32 bits.
  assign trial = {r_r, q_r[31]};
  assign ge    = trial >= {1'b0, d_r};
  assign diff  = trial[31:0] - d_r;

  assign quotient  = q_r;
  assign remainder = r_r;

  // Load on start; each step restores or keeps the difference and shifts in a quotient bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
    end else if (start) begin
      q_r <= dividend;
      r_r <= '0;
      d_r <= divisor;
    end else if (step) begin
      r_r <= ge ? diff : trial[31:0];
      q_r <= {q_r[30:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage.
// Build option: MULDIV_DIV0_FAST_EN finishes divide-by-zero in one cycle
// with the same written values the full iteration would produce.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DIV_ITERS = DIV_ITERS_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [1:0]  hilo_we_o,
  output logic [31:0] hi_wdata_o,
  output logic [31:0] lo_wdata_o
);

  localparam int CNT_W = $clog2(DIV_ITERS + 1);

  state_t             state;
  logic [2:0]         op_q;
  logic [31:0]        a_q;
  logic               sa_q, sb_q, sgn_q, div0_q;
  logic [63:0]        prod_q;
  logic [CNT_W-1:0]   cnt;

  logic               sgn_i, accept, div_fast;
  logic [31:0]        a_abs_i, b_abs_i, a_abs_q;
  logic [63:0]        mul_a, mul_b, mul_p;
  logic [31:0]        div_q, div_r, q_raw, r_raw, quo, rem;

  // MTW behaves like IDLE for acceptance so back-to-back MT*/long ops flow
  assign accept = ((state == S_IDLE) || (state == S_MTW)) && op_valid_i && !flush_i &&
                  (is_long_op(op_i) || (op_i == OP_MTHI) || (op_i == OP_MTLO));
  assign sgn_i  = is_signed_op(op_i);

  assign a_abs_i = (sgn_i && src_a_i[31]) ? -src_a_i : src_a_i;
  assign b_abs_i = (sgn_i && src_b_i[31]) ? -src_b_i : src_b_i;

  // Sign/zero extend to 64 bits; the low 64 bits of the product are the same either way
  assign mul_a = {{32{sgn_i & src_a_i[31]}}, src_a_i};
  assign mul_b = {{32{sgn_i & src_b_i[31]}}, src_b_i};
  assign mul_p = mul_a * mul_b;

`ifdef MULDIV_DIV0_FAST_EN
  assign div_fast = (src_b_i == '0);
`else
  assign div_fast = 1'b0;
`endif

  div_radix2 u_div (
    .clk       (clk),
    .rst_n     (resetn),
    .start     (accept && is_div_op(op_i)),
    .step      (state == S_DIV),
    .dividend  (a_abs_i),
    .divisor   (b_abs_i),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Fast divide-by-zero substitutes what the full iteration would have produced
  assign a_abs_q = (sgn_q && sa_q) ? -a_q : a_q;
  assign q_raw   = div0_q ? '1 : div_q;
  assign r_raw   = div0_q ? a_abs_q : div_r;
  assign quo     = (sgn_q && (sa_q ^ sb_q)) ? -q_raw : q_raw;
  assign rem     = (sgn_q && sa_q) ? -r_raw : r_raw;

  // Sequencer: operand latch, product register, iteration count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      sgn_q  <= 1'b0;
      div0_q <= 1'b0;
      prod_q <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_MTW: begin
          if (accept) begin
            op_q   <= op_i;
            a_q    <= src_a_i;
            sa_q   <= src_a_i[31];
            sb_q   <= src_b_i[31];
            sgn_q  <= sgn_i;
            div0_q <= is_div_op(op_i) && div_fast;
            cnt    <= '0;
            if (is_div_op(op_i))
              state <= div_fast ? S_DONE : S_DIV;
            else if (is_long_op(op_i)) begin
              state  <= S_MUL;
              prod_q <= mul_p;
            end else
              state <= S_MTW;
          end else begin
            state <= S_IDLE;
          end
        end
        S_MUL: state <= S_DONE;
        S_DIV: begin
          if (cnt == CNT_W'(DIV_ITERS - 1)) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write port decode from registered state; flush kills the write
  always_comb begin
    hilo_we_o  = '0;
    hi_wdata_o = '0;
    lo_wdata_o = '0;
    case (state)
      S_DONE: begin
        hilo_we_o = 2'b11;
        if (is_div_op(op_q)) begin
          hi_wdata_o = rem;
          lo_wdata_o = quo;
        end else begin
          hi_wdata_o = prod_q[63:32];
          lo_wdata_o = prod_q[31:0];
        end
      end
      S_MTW: begin
        if (op_q == OP_MTHI) begin
          hilo_we_o[HILO_WE_HI] = 1'b1;
          hi_wdata_o            = a_q;
        end else begin
          hilo_we_o[HILO_WE_LO] = 1'b1;
          lo_wdata_o            = a_q;
        end
      end
      default: ;
    endcase
    if (flush_i) hilo_we_o = '0;
  end

  // Hold the pipeline from acceptance of a long op until its last busy cycle
  assign stall_o = !flush_i && ((accept && is_long_op(op_i)) || (state == S_MUL) || (state == S_DIV));
  assign busy_o  = (state != S_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; expectations are hand-computed.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

`ifdef MULDIV_DIV0_FAST_EN
  localparam int D0_LAT = 1;
`else
  localparam int D0_LAT = 33;
`endif

  logic        clk, resetn, op_valid, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall_o, busy_o;
  logic [1:0]  hilo_we_o;
  logic [31:0] hi_wdata_o, lo_wdata_o;

  int total = 0;
  int bad   = 0;

  muldiv_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .op_valid_i (op_valid),
    .op_i       (op),
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .flush_i    (flush),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .hilo_we_o  (hilo_we_o),
    .hi_wdata_o (hi_wdata_o),
    .lo_wdata_o (lo_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // From the current cycle, count cycles (and stalled cycles) until a write shows up
  task automatic wait_write(input string tag, input int exp_lat, input int exp_st,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat = 0;
    int st  = 0;
    bit got = 0;
    while (!got && lat < 100) begin
      #1;
      if (hilo_we_o != 2'b00) got = 1;
      else begin
        if (stall_o) st++;
        lat++;
        nxt();
      end
    end
    chk({tag, "_lat"},   lat, exp_lat);
    chk({tag, "_stall"}, st,  exp_st);
    chk({tag, "_we"},    hilo_we_o, 2'b11);
    chk({tag, "_hi"},    hi_wdata_o, exp_hi);
    chk({tag, "_lo"},    lo_wdata_o, exp_lo);
    chk({tag, "_dstall"}, stall_o, 1'b0);
    nxt();
    op_valid = 1'b0;
    #1;
    chk({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    wait_write(tag, lat, lat, exp_hi, exp_lo);
  endtask

  initial begin
    int wcnt;
    op_valid = 1'b0;
    op       = OP_MULT;
    src_a    = '0;
    src_b    = '0;
    flush    = 1'b0;
    resetn   = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_busy",  busy_o, 1'b0);
    chk("rst_we",    hilo_we_o, 2'b00);
    chk("rst_hi",    hi_wdata_o, 32'h0);
    chk("rst_lo",    lo_wdata_o, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;

    run_op("mult",   OP_MULT,  32'hFFFFFFFE, 32'd3, 2, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu",  OP_MULTU, 32'hFFFFFFFE, 32'd3, 2, 32'h00000002, 32'hFFFFFFFA);
    run_op("div_m7", OP_DIV,   32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_neg_b", OP_DIV, 32'd100, 32'hFFFFFFF9, 33, 32'd2, 32'hFFFFFFF2);
    run_op("divu",   OP_DIVU,  32'hFFFFFFFF, 32'd16, 33, 32'h0000000F, 32'h0FFFFFFF);
    run_op("div_wrap", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
    run_op("divu0",  OP_DIVU,  32'd100, 32'd0, D0_LAT, 32'd100, 32'hFFFFFFFF);
    run_op("div0_neg", OP_DIV, 32'hFFFFFFFB, 32'd0, D0_LAT, 32'hFFFFFFFB, 32'h00000001);
    run_op("div0_pos", OP_DIV, 32'd9, 32'd0, D0_LAT, 32'd9, 32'hFFFFFFFF);

    // MTHI with no stall, then a DIV accepted straight out of MTW
    op_valid = 1'b1; op = OP_MTHI; src_a = 32'h12345678; src_b = '0;
    #1;
    chk("mthi_stall", stall_o, 1'b0);
    chk("mthi_we0",   hilo_we_o, 2'b00);
    nxt();
    op = OP_DIV; src_a = 32'd20; src_b = 32'd3;
    #1;
    chk("mthi_we",    hilo_we_o, 2'b10);
    chk("mthi_hi",    hi_wdata_o, 32'h12345678);
    chk("mthi_dstall", stall_o, 1'b1);
    nxt();
    wait_write("mthi_div", 32, 32, 32'd2, 32'd6);

    // MTLO
    op_valid = 1'b1; op = OP_MTLO; src_a = 32'hCAFEF00D;
    #1;
    chk("mtlo_stall", stall_o, 1'b0);
    nxt();
    op_valid = 1'b0;
    #1;
    chk("mtlo_we", hilo_we_o, 2'b01);
    chk("mtlo_lo", lo_wdata_o, 32'hCAFEF00D);
    nxt();
    #1;
    chk("mtlo_after_we", hilo_we_o, 2'b00);

    // Flush at iteration 10 of a divide
    op_valid = 1'b1; op = OP_DIV; src_a = 32'd50; src_b = 32'd5;
    for (int i = 0; i < 11; i++) nxt();
    #1;
    chk("fl_busy", busy_o, 1'b1);
    flush = 1'b1;
    #1;
    chk("fl_stall", stall_o, 1'b0);
    chk("fl_we",    hilo_we_o, 2'b00);
    nxt();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk("fl_idle",   busy_o, 1'b0);
    chk("fl_stall2", stall_o, 1'b0);
    wcnt = 0;
    for (int i = 0; i < 40; i++) begin
      nxt();
      #1;
      if (hilo_we_o != 2'b00) wcnt++;
    end
    chk("fl_no_write", wcnt, 0);

    // Flush in DONE suppresses the write
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd7;
    nxt();
    nxt();
    flush = 1'b1;
    #1;
    chk("fldone_we", hilo_we_o, 2'b00);
    nxt();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk("fldone_idle", busy_o, 1'b0);

    // Asynchronous reset during a divide
    op_valid = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
    for (int i = 0; i < 5; i++) nxt();
    #1;
    chk("rd_busy", busy_o, 1'b1);
    resetn = 1'b0; op_valid = 1'b0;
    #1;
    chk("rd_stall", stall_o, 1'b0);
    chk("rd_busy0", busy_o, 1'b0);
    chk("rd_we",    hilo_we_o, 2'b00);
    chk("rd_hi",    hi_wdata_o, 32'h0);
    chk("rd_lo",    lo_wdata_o, 32'h0);
    nxt();
    nxt();
    resetn = 1'b1;
    nxt();
    run_op("mult56", OP_MULT, 32'd5, 32'd6, 2, 32'd0, 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
